// File: rtl/ball_axis_if.sv
// ball_axis_if -- signal bundle between a ball_axis instance and its user.
//
// Carries the scan coordinate, frame/serve/bounce controls and the ball
// status/video outputs. Clock and reset are not part of the bundle.
//
//   master : the surrounding game logic (drives i_*, observes o_*)
//   slave  : ball_axis (observes i_*, drives o_*)
//
// POS_WIDTH must match the POS_WIDTH of the connected ball_axis.

interface ball_axis_if #(
   parameter int POS_WIDTH = 9
);
   logic [POS_WIDTH-1:0] i_Scan_Pos;
   logic                 i_Scan_Valid;
   logic                 i_Frame_Tick;
   logic                 i_Serve;
   logic                 i_Serve_Dir;
   logic                 i_Bounce;

   logic                 o_Video;
   logic [POS_WIDTH-1:0] o_Pos;
   logic                 o_Dir;
   logic                 o_Moving;
   logic                 o_Hit_Low;
   logic                 o_Hit_High;

   modport master (
      output i_Scan_Pos, i_Scan_Valid, i_Frame_Tick, i_Serve, i_Serve_Dir, i_Bounce,
      input  o_Video, o_Pos, o_Dir, o_Moving, o_Hit_Low, o_Hit_High
   );

   modport slave (
      input  i_Scan_Pos, i_Scan_Valid, i_Frame_Tick, i_Serve, i_Serve_Dir, i_Bounce,
      output o_Video, o_Pos, o_Dir, o_Moving, o_Hit_Low, o_Hit_High
   );
endinterface

// File: rtl/ball_axis.sv
// ball_axis -- single-axis ball motion and video generator for Pong.
//
// One instance per axis. Holds the ball's low-edge position and direction,
// advances it once per frame tick, and either reflects at the playfield
// edges (BOUNCE_AT_EDGES=1) or stops at the edge and reports a miss
// (BOUNCE_AT_EDGES=0). o_Video is high one cycle after the scan coordinate
// falls inside the ball.
//
// Ports:
//   i_Clk    pixel clock
//   i_Reset  synchronous, active-high reset
//   bus      ball_axis_if.slave: scan pos/valid, frame tick, serve, serve
//            direction, bounce request in; video, pos, dir, moving, hit
//            pulses out
//
// Optional feature macro: BALL_SPEEDUP_EN -- each accepted bounce raises
// the per-frame step by one, saturating at MAX_STEP. Without it the step
// is the constant STEP and no step register exists.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | position frozen, frame ticks and bounce requests ignored
// MOVING | position advances by step on every frame tick

module ball_axis #(
   parameter int AXIS_LENGTH     = 480,
   parameter int BALL_SIZE       = 8,
   parameter int STEP            = 2,
   parameter int MAX_STEP        = 6,
   parameter int BOUNCE_AT_EDGES = 1,
   parameter int POS_WIDTH       = $clog2(AXIS_LENGTH)
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   ball_axis_if.slave bus
);

   localparam int POS_MAX = AXIS_LENGTH - BALL_SIZE;
   localparam int CENTRE  = POS_MAX / 2;
   // one extra bit so pos + step and pos + BALL_SIZE never wrap
   localparam int XW      = POS_WIDTH + 1;

   localparam logic [XW-1:0]        POS_MAX_X = XW'(POS_MAX);
   localparam logic [POS_WIDTH-1:0] POS_MAX_P = POS_WIDTH'(POS_MAX);
   localparam logic [POS_WIDTH-1:0] CENTRE_P  = POS_WIDTH'(CENTRE);
   localparam logic [XW-1:0]        SIZE_X    = XW'(BALL_SIZE);
   localparam logic [XW-1:0]        STEP_X    = XW'(STEP);

   typedef enum logic {
      IDLE   = 1'b0,
      MOVING = 1'b1
   } state_t;

   state_t               state_q;
   logic [POS_WIDTH-1:0] pos_q;
   logic                 dir_q;
   logic                 armed_q;
   logic                 hit_low_q;
   logic                 hit_high_q;
   logic                 video_q;
   logic [XW-1:0]        step_w;

`ifdef BALL_SPEEDUP_EN
   localparam logic [XW-1:0] MAX_STEP_X = XW'(MAX_STEP);
   logic [XW-1:0] step_q;
   assign step_w = step_q;
`else
   assign step_w = STEP_X;
`endif

   logic          bounce_acc;
   logic          dir_eff;
   logic          reach_high;
   logic          reach_low;
   logic          video_d;
   logic [XW-1:0] pos_x;
   logic [XW-1:0] scan_x;
   logic [XW-1:0] pos_up;
   logic [XW-1:0] pos_dn;

   always_comb begin
      pos_x      = {1'b0, pos_q};
      scan_x     = {1'b0, bus.i_Scan_Pos};
      bounce_acc = (state_q == MOVING) && armed_q && bus.i_Bounce;
      // a bounce in the same cycle as a tick steers that tick's move
      dir_eff    = dir_q ^ bounce_acc;
      pos_up     = pos_x + step_w;
      pos_dn     = pos_x - step_w;
      reach_high = (pos_up >= POS_MAX_X);
      reach_low  = (pos_x <= step_w);
      video_d    = bus.i_Scan_Valid && (scan_x >= pos_x) && (scan_x < pos_x + SIZE_X);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         pos_q      <= CENTRE_P;
         dir_q      <= 1'b1;
         armed_q    <= 1'b1;
         hit_low_q  <= 1'b0;
         hit_high_q <= 1'b0;
         video_q    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         step_q     <= STEP_X;
`endif
      end else begin
         video_q    <= video_d;
         hit_low_q  <= 1'b0;
         hit_high_q <= 1'b0;
         if (bus.i_Serve) begin
            state_q <= MOVING;
            pos_q   <= CENTRE_P;
            dir_q   <= bus.i_Serve_Dir;
            armed_q <= 1'b1;
`ifdef BALL_SPEEDUP_EN
            step_q  <= STEP_X;
`endif
         end else if (state_q == MOVING) begin
            // one accepted bounce per frame; the tick re-arms only when
            // it did not coincide with an accepted bounce
            if (bounce_acc) begin
               armed_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
               if (step_q < MAX_STEP_X) begin
                  step_q <= step_q + 1'b1;
               end
`endif
            end else if (bus.i_Frame_Tick) begin
               armed_q <= 1'b1;
            end
            dir_q <= dir_eff;
            if (bus.i_Frame_Tick) begin
               if (dir_eff) begin
                  if (reach_high) begin
                     pos_q      <= POS_MAX_P;
                     hit_high_q <= 1'b1;
                     if (BOUNCE_AT_EDGES != 0) dir_q   <= 1'b0;
                     else                      state_q <= IDLE;
                  end else begin
                     pos_q <= pos_up[POS_WIDTH-1:0];
                  end
               end else begin
                  if (reach_low) begin
                     pos_q     <= '0;
                     hit_low_q <= 1'b1;
                     if (BOUNCE_AT_EDGES != 0) dir_q   <= 1'b1;
                     else                      state_q <= IDLE;
                  end else begin
                     pos_q <= pos_dn[POS_WIDTH-1:0];
                  end
               end
            end
         end
      end
   end

   assign bus.o_Video    = video_q;
   assign bus.o_Pos      = pos_q;
   assign bus.o_Dir      = dir_q;
   assign bus.o_Moving   = (state_q == MOVING);
   assign bus.o_Hit_Low  = hit_low_q;
   assign bus.o_Hit_High = hit_high_q;

endmodule

// File: tb/tb_ball_axis.sv
// Testbench for ball_axis: a vertical (bouncing, STEP 2) and a horizontal
// (stop-on-miss, STEP 5) instance share the same stimulus. A behavioural
// model predicts every output each cycle; predictions are queued when the
// stimulus is applied and compared after the clock edge.

module tb_ball_axis;

   typedef struct {
      int pos;
      bit dir;
      bit mov;
      int step;
      bit armed;
      bit hl;
      bit hh;
      bit vid;
   } mdl_t;

   typedef struct {
      int bsize;
      int posmax;
      int step0;
      int maxstep;
      bit edges;
   } cfg_t;

   typedef struct {
      mdl_t v;
      mdl_t h;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [8:0] scan;
   logic       valid;
   logic       tick;
   logic       serve;
   logic       sdir;
   logic       bnc;

   int   checks;
   int   errors;
   mdl_t mv;
   mdl_t mh;
   cfg_t cfg_v;
   cfg_t cfg_h;
   exp_t sb[$];

   ball_axis_if #(.POS_WIDTH(9)) bus_v ();
   ball_axis_if #(.POS_WIDTH(9)) bus_h ();

   assign bus_v.i_Scan_Pos   = scan;
   assign bus_v.i_Scan_Valid = valid;
   assign bus_v.i_Frame_Tick = tick;
   assign bus_v.i_Serve      = serve;
   assign bus_v.i_Serve_Dir  = sdir;
   assign bus_v.i_Bounce     = bnc;
   assign bus_h.i_Scan_Pos   = scan;
   assign bus_h.i_Scan_Valid = valid;
   assign bus_h.i_Frame_Tick = tick;
   assign bus_h.i_Serve      = serve;
   assign bus_h.i_Serve_Dir  = sdir;
   assign bus_h.i_Bounce     = bnc;

   ball_axis #(.BOUNCE_AT_EDGES(1)) u_v (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus_v)
   );

   ball_axis #(.STEP(5), .BOUNCE_AT_EDGES(0)) u_h (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic mdl_t mdl_next(mdl_t s, cfg_t c);
      mdl_t n;
      bit   d;
      int   sc;
      n    = s;
      sc   = int'(scan);
      n.vid = valid && (sc >= s.pos) && (sc < s.pos + c.bsize);
      n.hl = 1'b0;
      n.hh = 1'b0;
      if (rst) begin
         n.pos   = c.posmax / 2;
         n.dir   = 1'b1;
         n.mov   = 1'b0;
         n.step  = c.step0;
         n.armed = 1'b1;
         n.vid   = 1'b0;
      end else if (serve) begin
         n.pos   = c.posmax / 2;
         n.dir   = sdir;
         n.mov   = 1'b1;
         n.step  = c.step0;
         n.armed = 1'b1;
      end else if (s.mov) begin
         d = s.dir;
         if (bnc && s.armed) begin
            d       = !d;
            n.armed = 1'b0;
`ifdef BALL_SPEEDUP_EN
            if (n.step < c.maxstep) n.step = n.step + 1;
`endif
         end else if (tick) begin
            n.armed = 1'b1;
         end
         n.dir = d;
         if (tick) begin
            if (d) begin
               if (s.pos + s.step >= c.posmax) begin
                  n.pos = c.posmax;
                  n.hh  = 1'b1;
                  if (c.edges) n.dir = 1'b0;
                  else         n.mov = 1'b0;
               end else begin
                  n.pos = s.pos + s.step;
               end
            end else begin
               if (s.pos <= s.step) begin
                  n.pos = 0;
                  n.hl  = 1'b1;
                  if (c.edges) n.dir = 1'b1;
                  else         n.mov = 1'b0;
               end else begin
                  n.pos = s.pos - s.step;
               end
            end
         end
      end
      return n;
   endfunction

   task automatic check_dut(input string who, input mdl_t e, input logic [8:0] pos,
                            input logic dir, input logic mov, input logic hl,
                            input logic hh, input logic vid);
      check_val({who, "_pos"},    32'(pos), 32'(e.pos));
      check_val({who, "_dir"},    32'(dir), 32'(e.dir));
      check_val({who, "_moving"}, 32'(mov), 32'(e.mov));
      check_val({who, "_hitlo"},  32'(hl),  32'(e.hl));
      check_val({who, "_hithi"},  32'(hh),  32'(e.hh));
      check_val({who, "_video"},  32'(vid), 32'(e.vid));
   endtask

   task automatic cyc();
      exp_t e;
      e.v = mdl_next(mv, cfg_v);
      e.h = mdl_next(mh, cfg_h);
      mv  = e.v;
      mh  = e.h;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_dut("v", e.v, bus_v.o_Pos, bus_v.o_Dir, bus_v.o_Moving,
                bus_v.o_Hit_Low, bus_v.o_Hit_High, bus_v.o_Video);
      check_dut("h", e.h, bus_h.o_Pos, bus_h.o_Dir, bus_h.o_Moving,
                bus_h.o_Hit_Low, bus_h.o_Hit_High, bus_h.o_Video);
      @(negedge clk);
   endtask

   task automatic tick_pair();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic do_serve(input logic dir);
      serve = 1'b1;
      sdir  = dir;
      cyc();
      serve = 1'b0;
   endtask

   task automatic tick_until(input bit use_h, input int target);
      int g;
      g = 0;
      while (((use_h ? mh.pos : mv.pos) != target) && g < 400) begin
         tick_pair();
         g++;
      end
      if (use_h) check_val("h_reach", 32'(bus_h.o_Pos), 32'(target));
      else       check_val("v_reach", 32'(bus_v.o_Pos), 32'(target));
   endtask

   initial begin
      int p0;
      int p1;
      int dlt;
      checks = 0;
      errors = 0;
      cfg_v  = '{bsize: 8, posmax: 472, step0: 2, maxstep: 6, edges: 1'b1};
      cfg_h  = '{bsize: 8, posmax: 472, step0: 5, maxstep: 6, edges: 1'b0};
      mv     = '{pos: 0, dir: 0, mov: 0, step: 0, armed: 0, hl: 0, hh: 0, vid: 0};
      mh     = mv;
      rst    = 1'b1;
      scan   = '0;
      valid  = 1'b0;
      tick   = 1'b0;
      serve  = 1'b0;
      sdir   = 1'b0;
      bnc    = 1'b0;
      @(negedge clk);

      // reset, then ticks while idle
      cyc();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick_pair();
      check_val("idle_pos",    32'(bus_v.o_Pos), 236);
      check_val("idle_moving", 32'(bus_v.o_Moving), 0);
      check_val("idle_video",  32'(bus_v.o_Video), 0);
      check_val("idle_hithi",  32'(bus_v.o_Hit_High), 0);

      // serve up, 10 frames, then scan the ball edges
      do_serve(1'b1);
      for (int i = 0; i < 10; i++) tick_pair();
      check_val("serve10_pos", 32'(bus_v.o_Pos), 256);
      valid = 1'b1; scan = 9'd256; cyc();
      check_val("vid_256", 32'(bus_v.o_Video), 1);
      scan = 9'd263; cyc();
      check_val("vid_263", 32'(bus_v.o_Video), 1);
      scan = 9'd255; cyc();
      check_val("vid_255", 32'(bus_v.o_Video), 0);
      scan = 9'd264; cyc();
      check_val("vid_264", 32'(bus_v.o_Video), 0);
      valid = 1'b0; scan = 9'd256; cyc();
      check_val("vid_novalid", 32'(bus_v.o_Video), 0);
      scan = '0;

      // held bounce inside one frame flips once
      bnc = 1'b1;
      for (int i = 0; i < 50; i++) cyc();
      bnc = 1'b0;
      check_val("held_bounce_dir", 32'(bus_v.o_Dir), 0);

      // vertical top edge reflection
      do_serve(1'b1);
      tick_until(1'b0, 470);
      tick = 1'b1; cyc(); tick = 1'b0;
      check_val("edge_pos",   32'(bus_v.o_Pos), 472);
      check_val("edge_hithi", 32'(bus_v.o_Hit_High), 1);
      check_val("edge_dir",   32'(bus_v.o_Dir), 0);
      cyc();
      check_val("edge_hithi_1cyc", 32'(bus_v.o_Hit_High), 0);
      tick_pair();
      check_val("edge_back", 32'(bus_v.o_Pos), 470);

      // horizontal miss at the low edge
      do_serve(1'b0);
      tick_until(1'b1, 1);
      tick = 1'b1; cyc(); tick = 1'b0;
      check_val("miss_pos",    32'(bus_h.o_Pos), 0);
      check_val("miss_hitlo",  32'(bus_h.o_Hit_Low), 1);
      check_val("miss_moving", 32'(bus_h.o_Moving), 0);
      cyc();
      for (int i = 0; i < 3; i++) tick_pair();
      check_val("miss_frozen", 32'(bus_h.o_Pos), 0);
      do_serve(1'b1);
      check_val("reserve_pos",    32'(bus_h.o_Pos), 236);
      check_val("reserve_moving", 32'(bus_h.o_Moving), 1);

      // bounce coincident with a tick uses the reversed direction
      do_serve(1'b0);
      tick_until(1'b0, 98);
      bnc = 1'b1; cyc(); bnc = 1'b0;
      tick_pair();
`ifndef BALL_SPEEDUP_EN
      check_val("pre_coinc_pos", 32'(bus_v.o_Pos), 100);
`endif
      check_val("pre_coinc_dir", 32'(bus_v.o_Dir), 1);
      bnc = 1'b1; tick = 1'b1; cyc(); bnc = 1'b0; tick = 1'b0;
      check_val("coinc_pos", 32'(bus_v.o_Pos), 98);
      check_val("coinc_dir", 32'(bus_v.o_Dir), 0);

      // six accepted bounces, then measure the step
      do_serve(1'b1);
      for (int i = 0; i < 6; i++) begin
         bnc = 1'b1; cyc(); bnc = 1'b0;
         tick_pair();
      end
      p0 = int'(bus_v.o_Pos);
      tick = 1'b1; cyc(); tick = 1'b0;
      p1 = int'(bus_v.o_Pos);
      dlt = (p1 > p0) ? p1 - p0 : p0 - p1;
`ifdef BALL_SPEEDUP_EN
      check_val("step_sat", 32'(dlt), 6);
`else
      check_val("step_const", 32'(dlt), 2);
`endif
      cyc();

      // serve beats bounce and tick in the same cycle
      do_serve(1'b1);
      tick_until(1'b0, 300);
      serve = 1'b1; sdir = 1'b0; bnc = 1'b1; tick = 1'b1;
      cyc();
      serve = 1'b0; bnc = 1'b0; tick = 1'b0;
      check_val("sbt_pos",   32'(bus_v.o_Pos), 236);
      check_val("sbt_dir",   32'(bus_v.o_Dir), 0);
      check_val("sbt_hithi", 32'(bus_v.o_Hit_High), 0);
      check_val("sbt_hitlo", 32'(bus_v.o_Hit_Low), 0);

      // reset in the middle of a move
      for (int i = 0; i < 3; i++) tick_pair();
      rst = 1'b1; tick = 1'b1; cyc();
      rst = 1'b0; tick = 1'b0;
      check_val("rst_mid_pos",    32'(bus_v.o_Pos), 236);
      check_val("rst_mid_moving", 32'(bus_v.o_Moving), 0);
      check_val("rst_mid_dir",    32'(bus_v.o_Dir), 1);
      tick_pair();
      check_val("rst_mid_frozen", 32'(bus_v.o_Pos), 236);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_axis.md
Name: ball_axis

Overview:
- Generic single-axis ball motion and video generator for the Pong datapath; one instance per axis (horizontal and vertical).
- Holds an explicit ball position and direction, and advances the position once per frame.
- Bounces at the playfield edges or stops and reports a miss, selected by parameter.
- Asserts the axis component of the ball video when the scan coordinate lies inside the ball.

Parameters:
- AXIS_LENGTH, 480, visible pixels/lines on this axis.
- BALL_SIZE, 8, ball extent on this axis, in pixels.
- STEP, 2, position increment per frame (serve speed).
- MAX_STEP, 6, step ceiling; only used when BALL_SPEEDUP_EN is defined.
- BOUNCE_AT_EDGES, 1, 1 = reflect at edges (vertical axis), 0 = stop at edge and go IDLE (horizontal axis, miss).
- POS_WIDTH, $clog2(AXIS_LENGTH), width of the position bus.

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  synchronous, active-high reset
- i_Scan_Pos  in  POS_WIDTH  current pixel/line coordinate
- i_Scan_Valid  in  1  scan coordinate is inside the visible area
- i_Frame_Tick  in  1  one-cycle pulse, once per frame, at start of vertical blanking
- i_Serve  in  1  pulse: recentre the ball and start moving
- i_Serve_Dir  in  1  direction at serve (1 = increasing coordinate)
- i_Bounce  in  1  external reflect request (paddle hit); level, may be held many cycles
- o_Video  out  1  ball covers the scan coordinate on this axis (registered)
- o_Pos  out  POS_WIDTH  ball's low edge coordinate
- o_Dir  out  1  current direction
- o_Moving  out  1  state is MOVING
- o_Hit_Low  out  1  one-cycle pulse when the ball reaches coordinate 0
- o_Hit_High  out  1  one-cycle pulse when the ball reaches POS_MAX

Behaviour:
- Derived constants: POS_MAX = AXIS_LENGTH - BALL_SIZE; CENTRE = POS_MAX/2 (defaults: 472, 236).
- Reset values: pos = CENTRE, dir = 1, state IDLE, step = STEP, bounce_armed = 1, o_Video = 0, both hit pulses 0.
- States:
  - IDLE: position frozen; frame ticks and i_Bounce are ignored.
  - MOVING: position advances on frame ticks.
- Serve: i_Serve in any state -> next cycle pos = CENTRE, dir = i_Serve_Dir, state MOVING, step = STEP, bounce_armed = 1.
- Priority: reset > serve > bounce > frame tick.
- Bounce:
  - In MOVING with bounce_armed = 1, i_Bounce = 1 -> dir inverts and bounce_armed clears.
  - bounce_armed sets again on the next i_Frame_Tick, so a held i_Bounce causes exactly one reversal per frame.
- Bounce and tick in the same cycle: the move uses the inverted direction.
- Move on i_Frame_Tick in MOVING; arithmetic uses POS_WIDTH+1 bits, so there is no wrap-around.
  - dir = 1: if pos + step >= POS_MAX -> pos = POS_MAX, o_Hit_High pulses; else pos += step.
  - dir = 0: if pos <= step -> pos = 0, o_Hit_Low pulses; else pos -= step.
- On an edge hit:
  - BOUNCE_AT_EDGES = 1: dir inverts.
  - BOUNCE_AT_EDGES = 0: state becomes IDLE and dir is unchanged.
- Hit pulses last exactly one cycle and are registered together with the position update.
- o_Video is registered with 1-cycle latency: o_Video(t+1) = i_Scan_Valid(t) && pos <= i_Scan_Pos(t) < pos + BALL_SIZE, evaluated with the position value at cycle t.
- A frame-tick move is visible at o_Pos one cycle after the tick.
- Reset mid-frame or mid-move takes effect in the next cycle; no partial update survives it.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined: each accepted i_Bounce increments step by 1, saturating at MAX_STEP; edge reflections do not change step; serve and reset restore STEP.
- Undefined: step is constant STEP, MAX_STEP is ignored, and no step register is inferred.

Test Plan:
- Reset, then 5 frame ticks -> o_Pos 236, o_Moving 0, o_Video 0, no hit pulses.
- Serve with dir 1, then 10 ticks -> o_Pos 256. Scan at 256 and 263 with valid -> o_Video 1 one cycle later. Scan at 255, at 264, or at 256 with valid 0 -> o_Video 0.
- BOUNCE_AT_EDGES 1, pos 470, dir 1: tick -> pos 472, o_Hit_High high for 1 cycle, dir 0; next tick -> 470.
- BOUNCE_AT_EDGES 0, pos 1, dir 0: tick -> pos 0, o_Hit_Low pulse, o_Moving 0; 3 further ticks -> pos stays 0; serve -> pos 236, moving.
- i_Bounce held 50 cycles inside one frame -> exactly one dir flip. Bounce coincident with a tick at pos 100, dir 1 -> pos 98. With BALL_SPEEDUP_EN, 6 accepted bounces from STEP 2 -> step saturates at 6.
- Serve, bounce and tick in the same cycle at pos 300 -> pos 236, dir = i_Serve_Dir, no hit pulse.
